// File: rtl/puf_eval_if.sv
// Control/response interface of the bistable-ring PUF evaluation controller.
// Handshake: start is level-sampled only while idle; resp_valid is a one-cycle strobe with no backpressure.
interface puf_eval_if #(
  parameter int NUM_LEN = 3,
  parameter int VOTES   = 5
);
  localparam int SEL_W = (NUM_LEN > 1) ? $clog2(NUM_LEN) : 1;
  localparam int CNT_W = (VOTES > 1) ? $clog2(VOTES + 1) : 1;

  logic [SEL_W-1:0] len_sel;
  logic             start;
  logic             abort;
  logic             busy;
  logic             resp_valid;
  logic             resp;
  logic [CNT_W-1:0] ones_cnt;

  modport master (
    output len_sel, start, abort,
    input  busy, resp_valid, resp, ones_cnt
  );

  modport slave (
    input  len_sel, start, abort,
    output busy, resp_valid, resp, ones_cnt
  );
endinterface

// File: rtl/puf_eval_ctrl.sv
// Evaluation sequencer for a family of bistable-ring PUFs: owns the serial challenge,
// cycles reset/settle/sample on the selected ring VOTES times and majority-votes the result.
module puf_eval_ctrl #(
  parameter int CHAL_W     = 128,
  parameter int NUM_LEN    = 3,
  parameter int RST_CYC    = 4,
  parameter int SETTLE_CYC = 16,
  parameter int VOTES      = 5
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               si,
  input  logic               shift_en,
  output logic               so,
  puf_eval_if.slave          ctl,
  output logic [NUM_LEN-1:0] puf_reset,
  output logic [CHAL_W-1:0]  puf_chal,
  input  logic [NUM_LEN-1:0] puf_out,
  output logic [2:0]         dbg_state
);
  localparam int SEL_W  = (NUM_LEN > 1) ? $clog2(NUM_LEN) : 1;
  localparam int CNT_W  = (VOTES > 1) ? $clog2(VOTES + 1) : 1;
  localparam int VC_W   = (VOTES > 1) ? $clog2(VOTES) : 1;
  localparam int PH_MAX = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(NUM_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RST    = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CHAL_W-1:0]  c_q, c_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic [VC_W-1:0]    vote_q, vote_d;
  logic [CNT_W-1:0]   ones_q, ones_d;
  logic               resp_q, resp_d;
  logic [NUM_LEN-1:0] sync1_q, sync1_d;
  logic [NUM_LEN-1:0] sync2_q, sync2_d;

  logic               busy;
  logic [SEL_W-1:0]   sel_in;
  logic [NUM_LEN-1:0] sel_oh;
  logic               sample_bit;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      c_q     <= '0;
      sel_q   <= '0;
      ph_q    <= '0;
      vote_q  <= '0;
      ones_q  <= '0;
      resp_q  <= 1'b0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      sel_q   <= sel_d;
      ph_q    <= ph_d;
      vote_q  <= vote_d;
      ones_q  <= ones_d;
      resp_q  <= resp_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign busy   = (state_q == S_RST) || (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign sel_in = (ctl.len_sel > MAX_SEL) ? MAX_SEL : ctl.len_sel;

  always_comb begin
    sel_oh = '0;
    for (int k = 0; k < NUM_LEN; k++) begin
      sel_oh[k] = (sel_q == SEL_W'(k));
    end
  end

  assign sample_bit = |(sync2_q & sel_oh);

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    sel_d   = sel_q;
    ph_d    = ph_q;
    vote_d  = vote_q;
    ones_d  = ones_q;
    resp_d  = resp_q;
    sync1_d = puf_out;
    sync2_d = sync1_q;

    // Challenge is frozen for the whole evaluation so every vote sees the same ring.
    if (shift_en && !busy) begin
      c_d = {c_q[CHAL_W-2:0], si};
    end

    case (state_q)
      S_IDLE: begin
        if (ctl.start && !ctl.abort) begin
          sel_d   = sel_in;
          ones_d  = '0;
          vote_d  = '0;
          ph_d    = '0;
          state_d = S_RST;
        end
      end
      S_RST: begin
        if (ph_q == PH_W'(RST_CYC - 1)) begin
          ph_d    = '0;
          state_d = S_SETTLE;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_SETTLE: begin
        if (ph_q == PH_W'(SETTLE_CYC - 1)) begin
          ph_d    = '0;
          state_d = S_SAMPLE;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_SAMPLE: begin
        ones_d = ones_q + CNT_W'(sample_bit);
        if (vote_q == VC_W'(VOTES - 1)) begin
          resp_d  = (ones_d > CNT_W'(VOTES / 2));
          state_d = S_DONE;
        end else begin
          vote_d  = vote_q + VC_W'(1);
          state_d = S_RST;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort keeps the partial vote count visible and leaves the last response untouched.
    if (ctl.abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      ones_d  = ones_q;
      resp_d  = resp_q;
    end
  end

  assign puf_reset      = ((state_q == S_SETTLE) || (state_q == S_SAMPLE)) ? ~sel_oh : '1;
  assign puf_chal       = c_q;
  assign so             = c_q[CHAL_W-1];
  assign ctl.busy       = busy;
  assign ctl.resp_valid = (state_q == S_DONE);
  assign ctl.resp       = resp_q;
  assign ctl.ones_cnt   = ones_q;
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Bench for puf_eval_ctrl: directed evaluations with a response scoreboard and per-cycle ring-reset checks.
module tb_puf_eval_ctrl;
  localparam int W   = 4;
  localparam int LAT = 105;

  logic         clk;
  logic         rstn;
  logic         si;
  logic         shift_en;
  logic         so;
  logic [2:0]   puf_reset;
  logic [127:0] puf_chal;
  logic [2:0]   puf_out;
  logic [2:0]   dbg_state;

  puf_eval_if #(.NUM_LEN(3), .VOTES(5)) ctl ();

  puf_eval_ctrl dut (
    .clk       (clk),
    .rstn      (rstn),
    .si        (si),
    .shift_en  (shift_en),
    .so        (so),
    .ctl       (ctl),
    .puf_reset (puf_reset),
    .puf_chal  (puf_chal),
    .puf_out   (puf_out),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  logic [127:0] pat;
  logic [127:0] chal_exp;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (ctl.resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL resp_unexpected: got resp_valid=1 expected no response (cycle %0d)", cyc);
      end else begin
        logic [W-1:0] e;
        int           ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("resp_ones", {ctl.resp, ctl.ones_cnt}, e);
        check("resp_latency", cyc, ec);
      end
    end
  end

  // driver tasks
  task automatic shift_bit(input logic b);
    si       = b;
    shift_en = 1'b1;
    @(posedge clk);
    #1;
    shift_en = 1'b0;
    si       = 1'b0;
  endtask

  task automatic run_eval(input logic [1:0] sel, input logic [14:0] pv,
                          input logic [W-1:0] exp, input bit poke);
    int         eff;
    logic [2:0] exp_rst;
    eff         = (sel > 2) ? 2 : int'(sel);
    ctl.len_sel = sel;
    ctl.start   = 1'b1;
    @(posedge clk);
    #1;
    ctl.start = 1'b0;
    exp_q.push_back(exp);
    exp_cyc_q.push_back(cyc + LAT);
    for (int j = 0; j < LAT; j++) begin
      if ((j % 21) == 4) puf_out = pv[(j / 21) * 3 +: 3];
      if (poke && j == 50) begin
        ctl.start = 1'b1;
        shift_en  = 1'b1;
        si        = 1'b1;
      end
      if (poke && j == 51) begin
        ctl.start = 1'b0;
        shift_en  = 1'b0;
        si        = 1'b0;
      end
      @(negedge clk);
      exp_rst = 3'b111;
      if ((j % 21) >= 4) exp_rst[eff] = 1'b0;
      check("puf_reset", puf_reset, exp_rst);
      check("busy_eval", ctl.busy, 1'b1);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("busy_done", ctl.busy, 1'b0);
    check("puf_reset_done", puf_reset, 3'b111);
    check("chal_frozen", puf_chal, chal_exp);
    @(posedge clk);
    #1;
    check("busy_after", ctl.busy, 1'b0);
  endtask

  initial begin
    rstn        = 1'b0;
    si          = 1'b0;
    shift_en    = 1'b0;
    puf_out     = 3'b000;
    ctl.len_sel = '0;
    ctl.start   = 1'b0;
    ctl.abort   = 1'b0;
    pat         = 128'hDEADBEEF_0123_4567_89AB_CDEF_FEDC_BA98;
    repeat (3) @(posedge clk);
    #1;

    check("rst_busy", ctl.busy, 1'b0);
    check("rst_resp_valid", ctl.resp_valid, 1'b0);
    check("rst_resp", ctl.resp, 1'b0);
    check("rst_ones", ctl.ones_cnt, 3'd0);
    check("rst_puf_reset", puf_reset, 3'b111);
    check("rst_chal", puf_chal, 128'd0);
    check("rst_so", so, 1'b0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // challenge load, MSB first
    for (int i = 127; i >= 0; i--) shift_bit(pat[i]);
    check("chal_load", puf_chal, pat);
    check("so_load", so, pat[127]);
    shift_bit(1'b0);
    chal_exp = {pat[126:0], 1'b0};
    check("so_shift", so, pat[126]);
    check("chal_shift", puf_chal, chal_exp);

    // ring 0, all ones
    run_eval(2'd0, {5{3'b111}}, 4'b1101, 1'b0);
    // ring 1, samples 1,0,1,0,0 with neighbours held high
    run_eval(2'd1, {3'b101, 3'b101, 3'b111, 3'b101, 3'b111}, 4'b0010, 1'b0);
    // clamped select, start/shift poked mid-evaluation
    run_eval(2'd3, {5{3'b100}}, 4'b1101, 1'b1);

    // abort after the first vote has been sampled
    ctl.len_sel = 2'd0;
    puf_out     = 3'b111;
    ctl.start   = 1'b1;
    @(posedge clk);
    #1;
    ctl.start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    ctl.abort = 1'b1;
    @(negedge clk);
    check("abort_busy_before", ctl.busy, 1'b1);
    @(posedge clk);
    #1;
    ctl.abort = 1'b0;
    @(negedge clk);
    check("abort_busy", ctl.busy, 1'b0);
    check("abort_puf_reset", puf_reset, 3'b111);
    check("abort_ones", ctl.ones_cnt, 3'd1);
    check("abort_resp", ctl.resp, 1'b1);
    repeat (120) @(posedge clk);
    #1;
    check("abort_idle", ctl.busy, 1'b0);

    // full evaluation after abort: ring 0 samples 1,1,0,1,0
    run_eval(2'd0, {3'b110, 3'b111, 3'b110, 3'b111, 3'b111}, 4'b1011, 1'b0);

    // asynchronous reset mid-SETTLE
    ctl.start = 1'b1;
    @(posedge clk);
    #1;
    ctl.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("pre_rst_busy", ctl.busy, 1'b1);
    rstn = 1'b0;
    #1;
    check("arst_busy", ctl.busy, 1'b0);
    check("arst_puf_reset", puf_reset, 3'b111);
    check("arst_chal", puf_chal, 128'd0);
    check("arst_resp", ctl.resp, 1'b0);
    check("arst_ones", ctl.ones_cnt, 3'd0);
    check("arst_resp_valid", ctl.resp_valid, 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int k = 0; k < 13; k++) begin
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("post_rst_idle", ctl.busy, 1'b0);
      check("post_rst_puf_reset", puf_reset, 3'b111);
    end

    check("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
